// File: rtl/ksa.sv
// ARC4 key-schedule engine: swaps S[i] and S[j] in an external S memory that has been pre-initialised to S[i]=i.
// Optional build macro KSA_SAME_IDX_SKIP_EN skips the read-back/write pair whenever the new j equals i.
module ksa #(
   parameter int unsigned KEY_LEN = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_LEN-1:0]   key,
   output logic [7:0]             addr,
   input  logic [7:0]             rddata,
   output logic [7:0]             wrdata,
   output logic                   wren
);

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      RD_J,
      LATCH_J,
      WR_I,
      WR_J
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           i_q, i_d;
   logic [7:0]           j_q, j_d;
   logic [7:0]           si_q, si_d;
   logic [7:0]           sj_q, sj_d;
   logic [1:0]           k_q, k_d;
   logic [8*KEY_LEN-1:0] key_q, key_d;

   logic [7:0]           key_byte;
   logic [7:0]           j_new;
   logic [1:0]           k_next;
   logic                 last_i;

   always_comb begin
      key_byte = '0;
      case (k_q)
         2'd0:    key_byte = key_q[8*KEY_LEN-1 -: 8];
         2'd1:    key_byte = key_q[8*KEY_LEN-9 -: 8];
         default: key_byte = key_q[8*KEY_LEN-17 -: 8];
      endcase
   end

   assign j_new  = j_q + rddata + key_byte;
   assign k_next = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
   assign last_i = (i_q == 8'hFF);
   assign rdy    = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      k_d     = k_q;
      key_d   = key_q;
      addr    = '0;
      wrdata  = '0;
      wren    = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               key_d   = key;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = RD_I;
            end
         end
         RD_I: begin
            addr    = i_q;
            state_d = RD_J;
         end
         RD_J: begin
            si_d    = rddata;
            addr    = j_new;
            j_d     = j_new;
            state_d = LATCH_J;
`ifdef KSA_SAME_IDX_SKIP_EN
            // Swapping S[i] with itself is a no-op, so jump straight to the index advance.
            if (j_new == i_q) begin
               k_d = k_next;
               if (last_i) begin
                  state_d = IDLE;
               end else begin
                  i_d     = i_q + 8'd1;
                  state_d = RD_I;
               end
            end
`endif
         end
         LATCH_J: begin
            sj_d    = rddata;
            addr    = j_q;
            state_d = WR_I;
         end
         WR_I: begin
            addr    = i_q;
            wrdata  = sj_q;
            wren    = 1'b1;
            state_d = WR_J;
         end
         WR_J: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
            k_d    = k_next;
            if (last_i) begin
               state_d = IDLE;
            end else begin
               i_d     = i_q + 8'd1;
               state_d = RD_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         k_q     <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         k_q     <= k_d;
         key_q   <= key_d;
      end
   end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: synchronous-read S memory model plus a software ARC4 key-schedule golden model.
module tb_ksa;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   always #5 clk = ~clk;

   ksa #(.KEY_LEN(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   logic [7:0]  mem  [256];
   logic [7:0]  gold [256];
   logic        init_req;

   always @(posedge clk) begin
      if (init_req) begin
         for (int unsigned m = 0; m < 256; m++) mem[m] <= m[7:0];
      end else if (wren) begin
         mem[addr] <= wrdata;
      end
      rddata <= mem[addr];
   end

   logic [7:0]  wq_a [$];
   logic [7:0]  wq_d [$];
   int unsigned wcount;

   always @(negedge clk) begin
      if (wren) begin
         wq_a.push_back(addr);
         wq_d.push_back(wrdata);
         wcount++;
      end
   end

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int unsigned gold_run(input logic [23:0] k);
      logic [7:0]  j;
      logic [7:0]  t;
      logic [7:0]  kb;
      int unsigned eq;
      j  = '0;
      eq = 0;
      for (int unsigned i = 0; i < 256; i++) begin
         kb = k[8*(2 - (i % 3)) +: 8];
         j  = j + gold[i] + kb;
         if (32'(j) == i) eq++;
         t       = gold[i];
         gold[i] = gold[j];
         gold[j] = t;
      end
      return eq;
   endfunction

   function automatic int unsigned exp_cycles(input int unsigned eq);
`ifdef KSA_SAME_IDX_SKIP_EN
      return 1280 - 3 * eq;
`else
      return 1280 + 0 * eq;
`endif
   endfunction

   task automatic init_mem();
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      for (int unsigned m = 0; m < 256; m++) gold[m] = m[7:0];
      wq_a.delete();
      wq_d.delete();
   endtask

   task automatic check_mem(input string tag);
      int unsigned bad;
      int unsigned dup;
      logic        seen [256];
      bad = 0;
      dup = 0;
      for (int unsigned m = 0; m < 256; m++) seen[m] = 1'b0;
      for (int unsigned m = 0; m < 256; m++) begin
         if (mem[m] !== gold[m]) begin
            if (bad == 0) $display("FAIL %s_entry: S[%0d] got 0x%0h, expected 0x%0h", tag, m, mem[m], gold[m]);
            bad++;
         end
         if (seen[mem[m]]) dup++;
         seen[mem[m]] = 1'b1;
      end
      chk({tag, "_mem_mismatches"}, bad, 0);
      chk({tag, "_perm_duplicates"}, dup, 0);
   endtask

   // Caller must be between clock edges; the next rising edge is the start edge.
   task automatic go(input logic [23:0] k, input bit hold, input bit keep,
                     input logic [23:0] k_alt, input int unsigned chg_at,
                     input int unsigned rst_at, output int unsigned cyc);
      int unsigned wc;
      key = k;
      en  = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_low_after_start", rdy, 0);
      if (!hold) en = 1'b0;
      cyc = 0;
      while (!rdy && cyc < 3000) begin
         if (chg_at != 0 && cyc == chg_at) key = k_alt;
         if (rst_at != 0 && cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_rdy", rdy, 1);
            chk("async_rst_wren", wren, 0);
            chk("async_rst_addr", addr, 0);
            wc = wcount;
            repeat (3) @(posedge clk);
            #1;
            chk("no_writes_in_rst", wcount, wc);
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!keep) en = 1'b0;
   endtask

   typedef struct packed {
      logic [23:0] key;
      logic [31:0] wa;
      logic [31:0] wd;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cyc;
      int unsigned cyc2;
      int unsigned eq;
      int unsigned eq2;
      int unsigned a;
      int unsigned d;

      // First four writes of each run, hand-derived from S[i]=i.
      vecs[0] = '{key: 24'h010203, wa: 32'h00_01_01_03, wd: 32'h01_00_03_00};
      vecs[1] = '{key: 24'h000000, wa: 32'h00_00_01_01, wd: 32'h00_00_01_01};
      vecs[2] = '{key: 24'hFF0000, wa: 32'h00_FF_01_00, wd: 32'hFF_00_FF_01};
      vecs[3] = '{key: 24'h00033C, wa: 32'h00_00_01_04, wd: 32'h00_00_04_01};

      rst_n    = 1'b0;
      en       = 1'b0;
      key      = '0;
      init_req = 1'b0;
      wcount   = 0;

      #12;
      chk("reset_rdy", rdy, 1);
      chk("reset_wren", wren, 0);
      chk("reset_addr", addr, 0);
      chk("reset_wrdata", wrdata, 0);

      init_mem();
      rst_n = 1'b1;

      for (int unsigned v = 0; v < 4; v++) begin
         if (v != 0) init_mem();
         go(vecs[v].key, 1'b0, 1'b0, 24'h0, 0, 0, cyc);
         eq = gold_run(vecs[v].key);
         chk($sformatf("v%0d_cycles", v), cyc, exp_cycles(eq));
`ifndef KSA_SAME_IDX_SKIP_EN
         for (int unsigned n = 0; n < 4; n++) begin
            a = 999;
            d = 999;
            if (n < wq_a.size()) begin
               a = wq_a[n];
               d = wq_d[n];
            end
            chk($sformatf("v%0d_wr%0d_addr", v, n), a, vecs[v].wa[31-8*n -: 8]);
            chk($sformatf("v%0d_wr%0d_data", v, n), d, vecs[v].wd[31-8*n -: 8]);
         end
`endif
         check_mem($sformatf("v%0d", v));
      end

      // en held high and key changed mid-run: must not restart nor pick up the new key.
      init_mem();
      go(24'h00033C, 1'b1, 1'b0, 24'hA5A5A5, 100, 0, cyc);
      eq = gold_run(24'h00033C);
      chk("hold_cycles", cyc, exp_cycles(eq));
      check_mem("hold");

      // Reset mid-run, then re-init and rerun.
      init_mem();
      go(24'h123456, 1'b0, 1'b0, 24'h0, 0, 600, cyc);
      init_mem();
      go(24'h123456, 1'b0, 1'b0, 24'h0, 0, 0, cyc);
      eq = gold_run(24'h123456);
      chk("post_rst_cycles", cyc, exp_cycles(eq));
      check_mem("post_rst");

      // Back-to-back: en still high when rdy rises; second run continues on the permuted S.
      init_mem();
      go(24'h010203, 1'b1, 1'b1, 24'h0, 0, 0, cyc);
      eq = gold_run(24'h010203);
      go(24'hC0FFEE, 1'b0, 1'b0, 24'h0, 0, 0, cyc2);
      eq2 = gold_run(24'hC0FFEE);
      chk("b2b_cycles1", cyc, exp_cycles(eq));
      chk("b2b_cycles2", cyc2, exp_cycles(eq2));
      check_mem("b2b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
